mem_if: RTL and testbench

Memory interface controller sitting directly upstream of the 32×16 unified memory in the multicycle processor. It accepts word requests from two requesters: the instruction-fetch path (read-only) and the load/store data path (read or write). It arbitrates between them and drives the memory's active-low read/write strobes for exactly one cycle per access. It then returns read data and a one-cycle acknowledge to the granted requester.

---
 rtl/mem_if_if.sv | 36 +++
 rtl/mem_if.sv | 139 +++++++++++++
 tb/tb_mem_if.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_if_if.sv
// Bus bundle between mem_if, its two requesters (fetch, load/store) and the unified memory.
// slave: the controller's view; master: the requester/memory environment's view.
interface mem_if_if #(
    parameter int DATA_W = 16,
    parameter int MEM_AW = 5
);
    logic              if_req;
    logic [15:0]       if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [15:0]       d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_in;
    logic              mem_write_n;
    logic              mem_read_n;
    logic [DATA_W-1:0] mem_out;
    logic              busy;
    logic              err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_out,
        output if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_in,
               mem_write_n, mem_read_n, busy, err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_out,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_in,
               mem_write_n, mem_read_n, busy, err
    );
endinterface

// File: rtl/mem_if.sv
// Arbitrates fetch and load/store word requests onto the 32x16 unified memory, one strobe
// cycle per access. Define MEMIF_RANGE_CHECK_EN to reject addresses beyond the memory depth.
module mem_if #(
    parameter int DATA_W = 16,
    parameter int MEM_AW = 5
) (
    input logic     clk,
    input logic     proc_rst,
    mem_if_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {FETCH, DATA} port_t;

    state_t            state;
    port_t             last_grant;
    port_t             cur_port;
    port_t             pick;
    logic              cur_we;
    logic              sel_we;
    logic              sel_oor;
    logic [MEM_AW-1:0] sel_addr;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_in_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              mem_write_n_q;
    logic              mem_read_n_q;
    logic              if_ack_q;
    logic              d_ack_q;
    logic              err_q;
    logic              busy_q;

    // On a tie the port not served last wins.
    always_comb begin
        pick = FETCH;
        if (bus.if_req && bus.d_req) begin
            pick = (last_grant == FETCH) ? DATA : FETCH;
        end else if (bus.d_req) begin
            pick = DATA;
        end
        sel_we   = (pick == DATA) && bus.d_we;
        sel_addr = (pick == DATA) ? bus.d_addr[MEM_AW-1:0] : bus.if_addr[MEM_AW-1:0];
    end

`ifdef MEMIF_RANGE_CHECK_EN
    always_comb begin
        sel_oor = (pick == DATA) ? (bus.d_addr[15:MEM_AW] != '0)
                                 : (bus.if_addr[15:MEM_AW] != '0);
    end
`else
    logic unused_upper_addr;
    assign unused_upper_addr = ^{bus.if_addr[15:MEM_AW], bus.d_addr[15:MEM_AW]};
    assign sel_oor = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (proc_rst) begin
            state         <= IDLE;
            last_grant    <= FETCH;
            cur_port      <= FETCH;
            cur_we        <= 1'b0;
            mem_addr_q    <= '0;
            mem_in_q      <= '0;
            if_rdata_q    <= '0;
            d_rdata_q     <= '0;
            mem_write_n_q <= 1'b1;
            mem_read_n_q  <= 1'b1;
            if_ack_q      <= 1'b0;
            d_ack_q       <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            err_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.if_req || bus.d_req) begin
                        last_grant <= pick;
                        cur_port   <= pick;
                        cur_we     <= sel_we;
                        busy_q     <= 1'b1;
                        if (sel_oor) begin
                            // Out-of-range: answer straight from RESP with no strobe.
                            state <= RESP;
                            err_q <= 1'b1;
                            if (pick == DATA) begin
                                d_ack_q <= 1'b1;
                                if (!sel_we) d_rdata_q <= '0;
                            end else begin
                                if_ack_q   <= 1'b1;
                                if_rdata_q <= '0;
                            end
                        end else begin
                            state      <= ACCESS;
                            mem_addr_q <= sel_addr;
                            if (pick == DATA) mem_in_q <= bus.d_wdata;
                            if (sel_we) mem_write_n_q <= 1'b0;
                            else        mem_read_n_q  <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    state         <= RESP;
                    mem_write_n_q <= 1'b1;
                    mem_read_n_q  <= 1'b1;
                    if (cur_port == DATA) begin
                        d_ack_q <= 1'b1;
                        if (!cur_we) d_rdata_q <= bus.mem_out;
                    end else begin
                        if_ack_q   <= 1'b1;
                        if_rdata_q <= bus.mem_out;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    busy_q        <= 1'b0;
                    mem_write_n_q <= 1'b1;
                    mem_read_n_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.if_ack      = if_ack_q;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.d_ack       = d_ack_q;
    assign bus.d_rdata     = d_rdata_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_in      = mem_in_q;
    assign bus.mem_write_n = mem_write_n_q;
    assign bus.mem_read_n  = mem_read_n_q;
    assign bus.busy        = busy_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_mem_if.sv
// Bench for mem_if: directed scenarios with literal expectations, then randomized requesters,
// all checked every cycle against a transaction-schedule model of the controller.
`timescale 1ns/1ps
module tb_mem_if;
    localparam int DATA_W = 16;
    localparam int MEM_AW = 5;

    logic clk = 1'b0;
    logic proc_rst;
    always #5 clk = ~clk;

    mem_if_if #(.DATA_W(DATA_W), .MEM_AW(MEM_AW)) bus ();
    mem_if #(.DATA_W(DATA_W), .MEM_AW(MEM_AW)) dut (.clk(clk), .proc_rst(proc_rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Unified memory: acts on the falling edge.
    logic [DATA_W-1:0] init_val [32];
    logic [DATA_W-1:0] mem_arr [32];
    bit mem_ready = 1'b0;
    always @(negedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 32; i++) mem_arr[i] = init_val[i];
            mem_ready = 1'b1;
        end
        if (!bus.mem_write_n) mem_arr[bus.mem_addr] = bus.mem_in;
        if (!bus.mem_read_n)  bus.mem_out = mem_arr[bus.mem_addr];
    end

    // Model: each grant schedules its strobe, ack and busy window by cycle number.
    int free_at = 0, strobe_cyc = -1, ack_cyc = -1, busy_end = -1;
    bit last_data = 1'b0, s_we, s_port, s_err, s_rd, model_ready = 1'b0, rst_cycle;
    logic [MEM_AW-1:0] s_addr;
    logic [15:0] s_wdata, s_rdata;
    logic [15:0] exp_if_rdata = '0, exp_d_rdata = '0;
    logic [15:0] model_mem [32];

    always @(posedge clk) begin
        bit p, w, oor;
        logic [15:0] a;
        #1;
        cyc++;
        if (!model_ready) begin
            for (int i = 0; i < 32; i++) model_mem[i] = init_val[i];
            model_ready = 1'b1;
        end
        rst_cycle = proc_rst;
        if (proc_rst) begin
            free_at = cyc + 1; strobe_cyc = -1; ack_cyc = -1; busy_end = -1;
            last_data = 1'b0; exp_if_rdata = '0; exp_d_rdata = '0;
        end else if (cyc >= free_at && (bus.if_req || bus.d_req)) begin
            p = (bus.if_req && bus.d_req) ? !last_data : bus.d_req;
            last_data = p;
            a = p ? bus.d_addr : bus.if_addr;
            w = p && bus.d_we;
`ifdef MEMIF_RANGE_CHECK_EN
            oor = (a >= 16'd32);
`else
            oor = 1'b0;
`endif
            s_port = p; s_rd = !w; s_err = oor;
            if (oor) begin
                ack_cyc = cyc; busy_end = cyc; free_at = cyc + 2; s_rdata = '0;
            end else begin
                strobe_cyc = cyc; s_we = w; s_addr = a % 32; s_wdata = bus.d_wdata;
                ack_cyc = cyc + 1; busy_end = cyc + 1; free_at = cyc + 3;
                if (w) model_mem[s_addr] = s_wdata;
                else   s_rdata = model_mem[s_addr];
            end
        end
        if (!proc_rst && cyc == ack_cyc && s_rd) begin
            if (s_port) exp_d_rdata = s_rdata;
            else        exp_if_rdata = s_rdata;
        end

        chk("mem_write_n", bus.mem_write_n, !(cyc == strobe_cyc && s_we));
        chk("mem_read_n", bus.mem_read_n, !(cyc == strobe_cyc && !s_we));
        chk("if_ack", bus.if_ack, cyc == ack_cyc && !s_port);
        chk("d_ack", bus.d_ack, cyc == ack_cyc && s_port);
        chk("err", bus.err, cyc == ack_cyc && s_err);
        chk("busy", bus.busy, cyc <= busy_end);
        chk("if_rdata", bus.if_rdata, exp_if_rdata);
        chk("d_rdata", bus.d_rdata, exp_d_rdata);
        if (cyc == strobe_cyc) begin
            chk("mem_addr", bus.mem_addr, s_addr);
            if (s_we) chk("mem_in", bus.mem_in, s_wdata);
        end
        if (rst_cycle) begin
            chk("rst_mem_addr", bus.mem_addr, 0);
            chk("rst_mem_in", bus.mem_in, 0);
        end
    end

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 16'($urandom);
        return 16'($urandom_range(0, 31));
    endfunction

    // One request on one port, held until its ack; reports what was seen per negedge.
    task automatic run_txn(input bit port, input bit we, input logic [15:0] addr,
                           input logic [15:0] wd, output int strobe_at, output int wstr,
                           output int rstr, output int ack_at, output logic [15:0] addr_s,
                           output logic [15:0] in_s, output logic [15:0] rdata_a,
                           output logic err_a);
        @(negedge clk);
        if (port) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wd;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        strobe_at = -1; ack_at = -1; wstr = 0; rstr = 0;
        addr_s = 'x; in_s = 'x; rdata_a = 'x; err_a = 1'bx;
        for (int i = 1; i <= 12 && ack_at < 0; i++) begin
            @(negedge clk);
            if (!bus.mem_write_n) begin wstr++; strobe_at = i; addr_s = 16'(bus.mem_addr); in_s = bus.mem_in; end
            if (!bus.mem_read_n)  begin rstr++; strobe_at = i; addr_s = 16'(bus.mem_addr); end
            if (port ? bus.d_ack : bus.if_ack) begin
                ack_at = i; rdata_a = port ? bus.d_rdata : bus.if_rdata; err_a = bus.err;
            end
        end
        chk("txn_ack_seen", ack_at >= 0, 1);
        @(negedge clk);
        bus.d_req = 1'b0;
        bus.if_req = 1'b0;
    endtask

    initial begin
        int st, ws, rs, ak, dat, fat, overlap, n, last, if_wait, d_wait;
        logic [15:0] as, is, rd;
        logic er;
        bit if_done, d_done;

        proc_rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        bus.d_addr = '0; bus.d_wdata = '0;
        for (int i = 0; i < 32; i++) init_val[i] = 16'($urandom);
        repeat (3) @(negedge clk);
        proc_rst = 1'b0;

        run_txn(1'b1, 1'b1, 16'h0003, 16'hA5C3, st, ws, rs, ak, as, is, rd, er);
        chk("wr_strobes", ws, 1); chk("wr_no_read", rs, 0); chk("wr_strobe_at", st, 1);
        chk("wr_addr", as, 16'h0003); chk("wr_data", is, 16'hA5C3); chk("wr_ack_at", ak, 2);

        run_txn(1'b0, 1'b0, 16'h0003, 16'h0000, st, ws, rs, ak, as, is, rd, er);
        chk("rd_strobes", rs, 1); chk("rd_no_write", ws, 0); chk("rd_ack_at", ak, 2);
        chk("rd_fetch_data", rd, 16'hA5C3);

        @(negedge clk); proc_rst = 1'b1;
        @(negedge clk); proc_rst = 1'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0001;
        bus.if_req = 1'b1; bus.if_addr = 16'h0007;
        dat = -1; fat = -1; overlap = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (dat >= 0) bus.d_req = 1'b0;
            if (fat >= 0) bus.if_req = 1'b0;
            if (!bus.mem_read_n && !bus.mem_write_n) overlap++;
            if (bus.d_ack) begin dat = i; rd = bus.d_rdata; end
            if (bus.if_ack) fat = i;
        end
        chk("tie_d_ack_at", dat, 2); chk("tie_if_ack_at", fat, 5); chk("tie_overlap", overlap, 0);
        chk("tie_d_rdata", rd, init_val[1]); chk("tie_if_rdata", bus.if_rdata, init_val[7]);

        @(negedge clk); bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0005;
        @(negedge clk); chk("rst_acc_strobe", bus.mem_read_n, 0); proc_rst = 1'b1; bus.d_req = 1'b0;
        @(negedge clk);
        chk("rst_acc_rd_n", bus.mem_read_n, 1); chk("rst_acc_wr_n", bus.mem_write_n, 1);
        chk("rst_acc_ack", bus.d_ack, 0); chk("rst_acc_busy", bus.busy, 0);
        chk("rst_acc_if_rdata", bus.if_rdata, 0); chk("rst_acc_addr", bus.mem_addr, 0);
        proc_rst = 1'b0;

        run_txn(1'b1, 1'b0, 16'h0003, 16'h0000, st, ws, rs, ak, as, is, rd, er);
        chk("ld_data", rd, 16'hA5C3);
        run_txn(1'b1, 1'b0, 16'h0020, 16'h0000, st, ws, rs, ak, as, is, rd, er);
`ifdef MEMIF_RANGE_CHECK_EN
        chk("oor_ack_at", ak, 1); chk("oor_no_strobe", ws + rs, 0);
        chk("oor_err", er, 1); chk("oor_rdata", rd, 16'h0000);
`else
        chk("trunc_ack_at", ak, 2); chk("trunc_addr", as, 16'h0000);
        chk("trunc_err", er, 0); chk("trunc_rdata", rd, mem_arr[0]);
`endif

        @(negedge clk); bus.if_req = 1'b1; bus.if_addr = 16'h0003;
        n = 0; last = -1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (n >= 4) bus.if_req = 1'b0;
            if (bus.if_ack) begin
                if (last >= 0) chk("b2b_gap", i - last, 3);
                last = i; n++;
            end
        end
        chk("b2b_acks", n, 4);

        if_done = 1'b0; d_done = 1'b0; if_wait = 0; d_wait = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (proc_rst) begin
                proc_rst = 1'b0;
            end else if ($urandom_range(0, 199) == 0) begin
                proc_rst = 1'b1; bus.if_req = 1'b0; bus.d_req = 1'b0;
                if_done = 1'b0; d_done = 1'b0; if_wait = 0; d_wait = 0;
            end
            if (!proc_rst) begin
                if (if_done) begin
                    if_done = 1'b0;
                    if ($urandom_range(0, 2) != 0) begin bus.if_req = 1'b1; bus.if_addr = rand_addr(); end
                    else bus.if_req = 1'b0;
                end else if (bus.if_ack) begin
                    if_done = 1'b1; if_wait = 0;
                end else if (!bus.if_req && $urandom_range(0, 3) == 0) begin
                    bus.if_req = 1'b1; bus.if_addr = rand_addr();
                end
                if (d_done) begin
                    d_done = 1'b0;
                    if ($urandom_range(0, 2) != 0) begin
                        bus.d_req = 1'b1; bus.d_we = 1'($urandom_range(0, 1));
                        bus.d_addr = rand_addr(); bus.d_wdata = 16'($urandom);
                    end else bus.d_req = 1'b0;
                end else if (bus.d_ack) begin
                    d_done = 1'b1; d_wait = 0;
                end else if (!bus.d_req && $urandom_range(0, 3) == 0) begin
                    bus.d_req = 1'b1; bus.d_we = 1'($urandom_range(0, 1));
                    bus.d_addr = rand_addr(); bus.d_wdata = 16'($urandom);
                end
                if (bus.if_req && !if_done) if_wait++;
                if (bus.d_req && !d_done) d_wait++;
                if (if_wait > 15) begin
                    checks++; errors++; if_wait = 0; bus.if_req = 1'b0;
                    $display("FAIL fetch_timeout: no if_ack within 15 cycles, required one");
                end
                if (d_wait > 15) begin
                    checks++; errors++; d_wait = 0; bus.d_req = 1'b0;
                    $display("FAIL data_timeout: no d_ack within 15 cycles, required one");
                end
            end
        end

        @(negedge clk);
        proc_rst = 1'b0; bus.if_req = 1'b0; bus.d_req = 1'b0;
        repeat (6) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
